// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: Wishbone classic slave that spreads one 32-bit bus port
// across NUM_BANKS 1rw1r SRAM macros. The RW port only writes and the R port
// only reads; the controller decodes the bank, pulses the active-low chip
// selects and absorbs the macro's one-cycle read latency.
//
// Build option: define SRAM_BANK_OOR_ERR_EN to add i_wb_adr_hi and answer
// accesses with non-zero upper address bits by o_wb_err, without touching the
// macros. Without it the upper bits do not exist and addresses wrap.
module sram_bank_ctrl #(
   parameter int NUM_BANKS  = 2,
   parameter int BANK_WORDS = 256,
   parameter int DW         = 32,
   localparam int SW  = DW / 8,
   localparam int RAW = $clog2(BANK_WORDS),
   localparam int BAW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
   localparam int AW  = RAW + BAW + 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [AW-1:0]           i_wb_adr,
`ifdef SRAM_BANK_OOR_ERR_EN
   input  logic [7:0]              i_wb_adr_hi,
`endif
   input  logic [DW-1:0]           i_wb_dat,
   input  logic [SW-1:0]           i_wb_sel,
   input  logic                    i_wb_we,
   input  logic                    i_wb_cyc,
   input  logic                    i_wb_stb,
   output logic [DW-1:0]           o_wb_rdt,
   output logic                    o_wb_ack,
   output logic                    o_wb_err,
   output logic [NUM_BANKS-1:0]    o_csb0,
   output logic                    o_web0,
   output logic [SW-1:0]           o_wmask0,
   output logic [RAW-1:0]          o_addr0,
   output logic [DW-1:0]           o_din0,
   output logic [NUM_BANKS-1:0]    o_csb1,
   output logic [RAW-1:0]          o_addr1,
   input  logic [NUM_BANKS*DW-1:0] i_dout1
);

   // Bank register needs at least one bit even when there is a single bank.
   localparam int BW = (BAW > 0) ? BAW : 1;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RDW,
      ACK
   } state_t;

   state_t              state, state_nxt;
   logic                live, live_nxt;      // master still holds cyc for this access
   logic [BW-1:0]       bank_q, bank_nxt;    // bank of the access in flight
   logic [BW-1:0]       bank_in;
   logic [RAW-1:0]      row_in;
   logic                oor_in;

   logic [NUM_BANKS-1:0] csb0_nxt, csb1_nxt;
   logic [SW-1:0]        wmask0_nxt;
   logic [RAW-1:0]       addr0_nxt, addr1_nxt;
   logic [DW-1:0]        din0_nxt, rdt_nxt;
   logic                 ack_nxt, err_nxt;

   // Byte-lane bits of the address carry no meaning for a word-wide memory.
   logic unused_adr;
   assign unused_adr = ^i_wb_adr[1:0];

   assign row_in = i_wb_adr[RAW+1:2];

   generate
      if (BAW > 0) begin : g_bank
         assign bank_in = i_wb_adr[AW-1:RAW+2];
      end else begin : g_one_bank
         assign bank_in = '0;
      end
   endgenerate

`ifdef SRAM_BANK_OOR_ERR_EN
   assign oor_in = |i_wb_adr_hi;
`else
   assign oor_in = 1'b0;
`endif

   // The macro write enable is never needed: the RW port is write-only here.
   assign o_web0 = 1'b0;

   // Next-state and next-output decode; every registered output is computed
   // one cycle ahead so that it is valid during the state it belongs to.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_nxt  = state;
      live_nxt   = live;
      bank_nxt   = bank_q;
      csb0_nxt   = '1;
      csb1_nxt   = '1;
      wmask0_nxt = o_wmask0;
      addr0_nxt  = o_addr0;
      din0_nxt   = o_din0;
      addr1_nxt  = o_addr1;
      rdt_nxt    = o_wb_rdt;
      ack_nxt    = 1'b0;
      err_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               live_nxt = 1'b1;
               bank_nxt = bank_in;
               if (oor_in) begin
                  state_nxt = ACK;
                  err_nxt   = 1'b1;
               end else if (i_wb_we && (i_wb_sel == '0)) begin
                  state_nxt = ACK;
                  ack_nxt   = 1'b1;
               end else if (i_wb_we) begin
                  state_nxt         = WR;
                  csb0_nxt[bank_in] = 1'b0;
                  addr0_nxt         = row_in;
                  din0_nxt          = i_wb_dat;
                  wmask0_nxt        = i_wb_sel;
               end else begin
                  state_nxt         = RD;
                  csb1_nxt[bank_in] = 1'b0;
                  addr1_nxt         = row_in;
               end
            end
         end
         WR: begin
            live_nxt  = live & i_wb_cyc;
            state_nxt = live_nxt ? ACK : IDLE;
            ack_nxt   = live_nxt;
         end
         RD: begin
            live_nxt  = live & i_wb_cyc;
            state_nxt = RDW;
         end
         RDW: begin
            live_nxt  = live & i_wb_cyc;
            rdt_nxt   = i_dout1[bank_q*DW +: DW];
            state_nxt = live_nxt ? ACK : IDLE;
            ack_nxt   = live_nxt;
         end
         ACK: begin
            live_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            live_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // update together from values sampled before the edge.
      if (i_rst) begin
         state    <= IDLE;
         live     <= 1'b0;
         bank_q   <= '0;
         o_csb0   <= '1;
         o_csb1   <= '1;
         o_wmask0 <= '0;
         o_addr0  <= '0;
         o_din0   <= '0;
         o_addr1  <= '0;
         o_wb_rdt <= '0;
         o_wb_ack <= 1'b0;
         o_wb_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         live     <= live_nxt;
         bank_q   <= bank_nxt;
         o_csb0   <= csb0_nxt;
         o_csb1   <= csb1_nxt;
         o_wmask0 <= wmask0_nxt;
         o_addr0  <= addr0_nxt;
         o_din0   <= din0_nxt;
         o_addr1  <= addr1_nxt;
         o_wb_rdt <= rdt_nxt;
         o_wb_ack <= ack_nxt;
         o_wb_err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl (default parameters): directed vector table,
// hand-written abort sequences and random traffic against a word-level model.
module tb_sram_bank_ctrl;

   localparam int NB    = 2;
   localparam int WORDS = 256;
   localparam int AW    = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] adr = '0;
   logic [7:0]    adr_hi = '0;
   logic [31:0]   dat = '0;
   logic [3:0]    sel = '0;
   logic          we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic [31:0]   rdt;
   logic          ack, err, web0;
   logic [NB-1:0] csb0, csb1;
   logic [3:0]    wmask0;
   logic [7:0]    addr0, addr1;
   logic [31:0]   din0;
   logic [NB*32-1:0] dout1;

   sram_bank_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_wb_adr(adr),
`ifdef SRAM_BANK_OOR_ERR_EN
      .i_wb_adr_hi(adr_hi),
`endif
      .i_wb_dat(dat), .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
      .o_wb_rdt(rdt), .o_wb_ack(ack), .o_wb_err(err),
      .o_csb0(csb0), .o_web0(web0), .o_wmask0(wmask0), .o_addr0(addr0), .o_din0(din0),
      .o_csb1(csb1), .o_addr1(addr1), .i_dout1(dout1)
   );

   always #5 clk = ~clk;

   // Behavioural 1rw1r macros: write on RW port, registered read on R port.
   logic [31:0] sram [0:NB-1][0:WORDS-1] = '{default: '0};
   logic [31:0] dout [0:NB-1] = '{32'h12345678, 32'h0};
   assign dout1 = {dout[1], dout[0]};

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (!csb0[b] && !web0)
            for (int i = 0; i < 4; i++)
               if (wmask0[i]) sram[b][addr0][i*8 +: 8] <= din0[i*8 +: 8];
         if (!csb1[b]) dout[b] <= sram[b][addr1];
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observations of one bus transaction.
   typedef struct packed {
      int          lat;
      bit          ack;
      bit          err;
      logic [31:0] rdt;
      int          wr_cnt;
      int          rd_cnt;
      int          wr_bank;
      int          wr_row;
      logic [3:0]  wr_mask;
      logic [31:0] wr_data;
      int          rd_bank;
      int          rd_row;
      bit          both;
   } res_t;

   task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, output res_t r);
      r   = '0;
      we  = w; adr = a; dat = d; sel = s;
      cyc = 1'b1; stb = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         for (int b = 0; b < NB; b++) begin
            if (!csb0[b]) begin
               r.wr_cnt++; r.wr_bank = b; r.wr_row = int'(addr0);
               r.wr_mask = wmask0; r.wr_data = din0;
            end
            if (!csb1[b]) begin
               r.rd_cnt++; r.rd_bank = b; r.rd_row = int'(addr1);
            end
         end
         if ((csb0 != '1) && (csb1 != '1)) r.both = 1'b1;
         if (ack || err) begin
            r.lat = n; r.ack = ack; r.err = err; r.rdt = rdt;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      tick();
   endtask

   // Word-level reference: flat memory indexed by word address, plus the last
   // value any completed read returned.
   logic [31:0] ref_mem [0:NB*WORDS-1] = '{default: '0};
   logic [31:0] last_rdt = '0;

   function automatic int word_of(input logic [AW-1:0] a);
      return int'(a) / 4;
   endfunction

   task automatic model_update(input bit w, input logic [AW-1:0] a,
                               input logic [31:0] d, input logic [3:0] s);
      int widx;
      widx = word_of(a);
      if (w) begin
         for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[widx][i*8 +: 8] = d[i*8 +: 8];
      end else begin
         last_rdt = ref_mem[widx];
      end
   endtask

   typedef struct packed {
      bit          we;
      logic [10:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          lat;
      logic [31:0] rdt;
      int          wr_cnt;
      int          rd_cnt;
      int          bank;
      int          row;
      logic [3:0]  mask;
   } vec_t;

   function automatic vec_t mk(bit w, logic [10:0] a, logic [31:0] d, logic [3:0] s,
                               int l, logic [31:0] r, int wc, int rc, int b, int ro,
                               logic [3:0] m);
      vec_t v;
      v.we = w; v.adr = a; v.dat = d; v.sel = s; v.lat = l; v.rdt = r;
      v.wr_cnt = wc; v.rd_cnt = rc; v.bank = b; v.row = ro; v.mask = m;
      return v;
   endfunction

   vec_t tbl [10];
   res_t r;

   initial begin
      tbl[0] = mk(1, 11'h404, 32'hDEADBEEF, 4'hF, 2, 32'h0,        1, 0, 1, 1,   4'hF);
      tbl[1] = mk(0, 11'h404, 32'h0,        4'h0, 3, 32'hDEADBEEF, 0, 1, 1, 1,   4'h0);
      tbl[2] = mk(1, 11'h404, 32'hFFFFFFFF, 4'h0, 1, 32'hDEADBEEF, 0, 0, 0, 0,   4'h0);
      tbl[3] = mk(1, 11'h404, 32'h00AB0000, 4'h4, 2, 32'hDEADBEEF, 1, 0, 1, 1,   4'h4);
      tbl[4] = mk(0, 11'h404, 32'h0,        4'h0, 3, 32'hDEABBEEF, 0, 1, 1, 1,   4'h0);
      tbl[5] = mk(1, 11'h008, 32'hCAFEF00D, 4'hF, 2, 32'hDEABBEEF, 1, 0, 0, 2,   4'hF);
      tbl[6] = mk(0, 11'h008, 32'h0,        4'h0, 3, 32'hCAFEF00D, 0, 1, 0, 2,   4'h0);
      tbl[7] = mk(0, 11'h405, 32'h0,        4'h0, 3, 32'hDEABBEEF, 0, 1, 1, 1,   4'h0);
      tbl[8] = mk(1, 11'h7FC, 32'h11223344, 4'h3, 2, 32'hDEABBEEF, 1, 0, 1, 255, 4'h3);
      tbl[9] = mk(0, 11'h7FE, 32'h0,        4'h0, 3, 32'h00003344, 0, 1, 1, 255, 4'h0);

      // Reset, then idle.
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("rst_csb0", 32'(csb0), 32'h3);
      check("rst_csb1", 32'(csb1), 32'h3);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_rdt", rdt, 32'h0);
      check("rst_addr0", 32'(addr0), 32'h0);
      check("rst_web0", 32'(web0), 32'h0);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, r);
         check($sformatf("v%0d_lat", i), r.lat, tbl[i].lat);
         check($sformatf("v%0d_ack", i), 32'(r.ack), 32'h1);
         check($sformatf("v%0d_rdt", i), r.rdt, tbl[i].rdt);
         check($sformatf("v%0d_wrcnt", i), r.wr_cnt, tbl[i].wr_cnt);
         check($sformatf("v%0d_rdcnt", i), r.rd_cnt, tbl[i].rd_cnt);
         check($sformatf("v%0d_both", i), 32'(r.both), 32'h0);
         if (tbl[i].wr_cnt != 0) begin
            check($sformatf("v%0d_wbank", i), r.wr_bank, tbl[i].bank);
            check($sformatf("v%0d_wrow", i), r.wr_row, tbl[i].row);
            check($sformatf("v%0d_wmask", i), 32'(r.wr_mask), 32'(tbl[i].mask));
            check($sformatf("v%0d_wdata", i), r.wr_data, tbl[i].dat);
         end
         if (tbl[i].rd_cnt != 0) begin
            check($sformatf("v%0d_rbank", i), r.rd_bank, tbl[i].bank);
            check($sformatf("v%0d_rrow", i), r.rd_row, tbl[i].row);
         end
         model_update(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel);
      end

      // Reset asserted while the read strobe is low on the macro.
      begin
         int acks;
         we = 1'b0; adr = 11'h404; cyc = 1'b1; stb = 1'b1;
         tick();
         check("rstrd_csb1_low", 32'(csb1), 32'h1);
         rst = 1'b1;
         tick();
         rst = 1'b0; cyc = 1'b0; stb = 1'b0;
         check("rstrd_csb0", 32'(csb0), 32'h3);
         check("rstrd_csb1", 32'(csb1), 32'h3);
         check("rstrd_ack", 32'(ack), 32'h0);
         check("rstrd_rdt", rdt, 32'h0);
         acks = 0;
         repeat (4) begin tick(); acks += int'(ack | err); end
         check("rstrd_noack", acks, 0);
         last_rdt = '0;
      end

      // cyc dropped during the read-wait cycle: no ack, then a clean read.
      begin
         int acks;
         we = 1'b0; adr = 11'h008; cyc = 1'b1; stb = 1'b1;
         tick();
         tick();
         cyc = 1'b0; stb = 1'b0;
         acks = 0;
         repeat (5) begin tick(); acks += int'(ack | err); end
         check("drop_noack", acks, 0);
         xfer(0, 11'h008, 32'h0, 4'h0, r);
         check("drop_read_lat", r.lat, 3);
         check("drop_read_rdt", r.rdt, ref_mem[2]);
         model_update(0, 11'h008, 32'h0, 4'h0);
      end

`ifdef SRAM_BANK_OOR_ERR_EN
      // Out-of-range upper bits: error in the ack slot, no macro access.
      adr_hi = 8'h01;
      xfer(1, 11'h404, 32'h55555555, 4'hF, r);
      adr_hi = 8'h00;
      check("oor_lat", r.lat, 1);
      check("oor_err", 32'(r.err), 32'h1);
      check("oor_ack", 32'(r.ack), 32'h0);
      check("oor_access", r.wr_cnt + r.rd_cnt, 0);
      check("oor_rdt", r.rdt, last_rdt);
`else
      // Byte address 0x808 does not fit the bus; it wraps onto word 2.
      xfer(0, 11'(12'h808), 32'h0, 4'h0, r);
      check("wrap_ack", 32'(r.ack), 32'h1);
      check("wrap_rdt", r.rdt, ref_mem[(32'h808 / 4) % (NB * WORDS)]);
      model_update(0, 11'(12'h808), 32'h0, 4'h0);
`endif

      // Random traffic against the word-level model.
      for (int k = 0; k < 150; k++) begin
         bit          w;
         int          bank, row, exp_lat;
         logic [AW-1:0] a;
         logic [31:0] d, exp_rdt;
         logic [3:0]  s;
         w    = 1'($urandom_range(0, 1));
         bank = $urandom_range(0, NB - 1);
         row  = ($urandom_range(0, 3) == 0) ? $urandom_range(WORDS - 4, WORDS - 1)
                                            : $urandom_range(0, 7);
         a    = AW'((bank * WORDS + row) * 4 + $urandom_range(0, 3));
         d    = $urandom;
         s    = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
         xfer(w, a, d, s, r);
         model_update(w, a, d, s);
         exp_lat = !w ? 3 : ((s == 4'h0) ? 1 : 2);
         exp_rdt = last_rdt;
         check($sformatf("r%0d_lat", k), r.lat, exp_lat);
         check($sformatf("r%0d_rdt", k), r.rdt, exp_rdt);
         check($sformatf("r%0d_wrcnt", k), r.wr_cnt, (w && s != 4'h0) ? 1 : 0);
         check($sformatf("r%0d_rdcnt", k), r.rd_cnt, w ? 0 : 1);
         if (w && s != 4'h0) begin
            check($sformatf("r%0d_wloc", k), r.wr_bank * WORDS + r.wr_row, bank * WORDS + row);
            check($sformatf("r%0d_wmask", k), 32'(r.wr_mask), 32'(s));
         end
         if (!w)
            check($sformatf("r%0d_rloc", k), r.rd_bank * WORDS + r.rd_row, bank * WORDS + row);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
Wishbone classic slave that maps one 32-bit bus port onto NUM_BANKS dual-port (1rw1r) SRAM macros of BANK_WORDS words each. The macro's RW port is used for writes only and its R port for reads only. It replaces the hard-wired single-macro hookup between the subservient core's memory/debug port and SRAM. It decodes the bank from the upper word-address bits, sequences active-low chip selects and absorbs the macro's one-cycle read latency.

Parameters:
NUM_BANKS, 2, number of SRAM macros; power of two, 1..8
BANK_WORDS, 256, words per macro; power of two
DW, 32, data width; multiple of 8
Derived (localparam): SW=DW/8; RAW=log2(BANK_WORDS); BAW=log2(NUM_BANKS), 0 when NUM_BANKS=1; AW=RAW+BAW+2 (byte address)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_wb_adr  in  AW  byte address; bits [1:0] ignored
i_wb_dat  in  DW  write data
i_wb_sel  in  SW  byte enables
i_wb_we  in  1  1=write
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
o_wb_rdt  out  DW  read data, registered
o_wb_ack  out  1  single-cycle acknowledge
o_wb_err  out  1  error acknowledge (see Optional Feature)
o_csb0  out  NUM_BANKS  per-bank RW-port chip select, active low
o_web0  out  1  shared write enable, active low; constant 0
o_wmask0  out  SW  shared write byte mask
o_addr0  out  RAW  shared RW-port word address
o_din0  out  DW  shared write data
o_csb1  out  NUM_BANKS  per-bank R-port chip select, active low
o_addr1  out  RAW  shared R-port word address
i_dout1  in  NUM_BANKS*DW  concatenated R-port data; bank b at [b*DW +: DW]

Behaviour:
- Address split: row = i_wb_adr[RAW+1:2]; bank = i_wb_adr[AW-1:RAW+2].
- All SRAM-side outputs and o_wb_* are registered.
- Reset values: o_csb0/o_csb1 all ones; o_wmask0, o_addr0, o_din0, o_addr1, o_wb_rdt = 0; o_wb_ack = o_wb_err = 0; state IDLE.
- FSM states:
  - IDLE: on i_wb_cyc & i_wb_stb, latch bank, row, data and sel.
    - Write, sel≠0 -> WR.
    - Write, sel=0 -> ACK; no macro access.
    - Read -> RD.
  - WR: o_csb0[bank]=0 for exactly this cycle; o_addr0=row, o_din0=data, o_wmask0=sel -> ACK.
  - RD: o_csb1[bank]=0 for exactly this cycle; o_addr1=row -> RDW.
  - RDW: capture i_dout1 slice of the latched bank into o_wb_rdt -> ACK.
  - ACK: o_wb_ack=1 for one cycle -> IDLE.
- Latency, from the cycle stb is sampled in IDLE to ack high: write 2 cycles; read 3 cycles; zero-sel write 1 cycle.
- Throughput: a new request is sampled no earlier than the cycle after ack. The master must deassert stb in the cycle after ack; the controller is in IDLE and samples stb again then.
- Non-selected banks keep their csb high at all times. At most one csb0 bit and one csb1 bit are low in any cycle, never both for the same access.
- o_wb_rdt holds its last read value through writes and idle; it changes only in RDW or on reset.
- i_wb_cyc dropped in WR/RD/RDW: the FSM runs to completion but suppresses ack/err and returns to IDLE. The macro access already issued completes; this is harmless.
- Reset asserted mid-transaction: next cycle all outputs return to reset values and state is IDLE. No ack is issued for the aborted access.
- NUM_BANKS=1: bank field is absent; o_csb*[0] is used for every access.

Optional Feature:
SRAM_BANK_OOR_ERR_EN
- Defined: o_wb_err is asserted instead of o_wb_ack, in the ack slot (1 cycle after sampling), for any access whose i_wb_adr bits above AW-1 are non-zero. The bus is wider than AW in this build, so an extra port i_wb_adr_hi [7:0] carries those bits. No macro access occurs and o_wb_rdt is unchanged.
- Undefined: i_wb_adr_hi is absent; o_wb_err is tied 0; upper address bits wrap modulo NUM_BANKS*BANK_WORDS words.

Test Plan:
- Reset, then idle 5 cycles -> o_csb0=o_csb1=2'b11, o_wb_ack=0, o_wb_rdt=0.
- Write 0xDEADBEEF to byte addr 0x0404 (bank 1, row 1), sel=4'hF -> o_csb0=2'b01 one cycle with o_addr0=1, o_wmask0=4'hF; ack 2 cycles after stb sampled.
- Read the same address with the model returning 0xDEADBEEF on bank 1 -> o_csb1=2'b01 one cycle, o_addr1=1; ack 3 cycles after stb, o_wb_rdt=0xDEADBEEF; bank-0 data 0x12345678 on i_dout1 is ignored.
- Write with sel=4'b0000 -> no csb0 low, ack after 1 cycle. Write with sel=4'b0100 data 0x00AB0000 -> o_wmask0=4'b0100, read back 0xXXABXXXX.
- Assert i_rst during RD -> next cycle csb all high, no ack. Drop cyc during RDW -> no ack, and a following read returns correctly.
- With SRAM_BANK_OOR_ERR_EN defined, access with i_wb_adr_hi=8'h01 -> o_wb_err=1 one cycle, o_wb_ack=0, no csb low. Without it, the same access aliases to bank 0 and acks.
